// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundles the requester handshake and the UART transmit
// path that uart_tx_arbiter sits between.
//   req/req_data   : level requests and their frames (requester i in
//                    req_data[i*DATA_W +: DATA_W])
//   grant/done     : one-hot pulses for frame acceptance / completion
//   timeout_err    : pulse when the UART never reported completion
//   busy/owner     : arbiter status (SEND or GAP / current or last owner)
//   tx_en/tx_data  : towards UART en_tx / data_in
//   tx_done        : from UART u_tx_done
// Modports: slave = arbiter side, master = clients + UART side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 128
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic                      timeout_err;
  logic                      busy;
  logic [2:0]                owner;
  logic                      tx_en;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_done;

  modport slave (
    input  req, req_data, tx_done,
    output grant, done, timeout_err, busy, owner, tx_en, tx_data
  );

  modport master (
    output req, req_data, tx_done,
    input  grant, done, timeout_err, busy, owner, tx_en, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmit path among
// NUM_REQ requesters. One frame at a time: IDLE -> SEND (tx_en held high
// until tx_done or timeout) -> GAP (GAP_CYCLES idle cycles) -> IDLE.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears every output and all state
//   bus   : uart_tx_arbiter_if.slave (requests, grant/done, UART side)
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 128,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [NUM_REQ-1:0] ONE = 1;

  logic [1:0]         state;
  logic [2:0]         ptr;
  logic [2:0]         sel;
  logic [31:0]        tcnt;
  logic [31:0]        gcnt;
  logic               tout_hit;
  logic [DATA_W-1:0]  sel_data;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done;
  logic               timeout_err;
  logic               busy;
  logic [2:0]         owner;
  logic               tx_en;
  logic [DATA_W-1:0]  tx_data;

  // First asserted request at or above p, wrapping modulo NUM_REQ.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                         input logic [2:0] p);
    logic [2:0] s;
    logic       f;
    int         k;
    s = 3'd0;
    f = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(p) + i) % NUM_REQ;
      if (!f && r[k[IDX_W-1:0]]) begin
        s = 3'(k);
        f = 1'b1;
      end
    end
    return s;
  endfunction

  function automatic logic [2:0] next_ptr(input logic [2:0] s);
    return 3'((int'(s) + 1) % NUM_REQ);
  endfunction

  assign sel = rr_pick(bus.req, ptr);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == 3'(i)) sel_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // A zero TIMEOUT_CYCLES disables the stuck-transmitter check entirely.
  assign tout_hit = (TIMEOUT_CYCLES != 0) && (tcnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      tcnt        <= '0;
      gcnt        <= '0;
      grant       <= '0;
      done        <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      owner       <= '0;
      tx_en       <= 1'b0;
      tx_data     <= '0;
    end else begin
      // grant/done/timeout_err are single-cycle pulses
      grant       <= '0;
      done        <= '0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            tx_data <= sel_data;
            tx_en   <= 1'b1;
            grant   <= ONE << sel;
            owner   <= sel;
            ptr     <= next_ptr(sel);
            tcnt    <= '0;
            busy    <= 1'b1;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          // tx_done has priority over a coincident timeout
          if (bus.tx_done) begin
            tx_en <= 1'b0;
            done  <= ONE << owner;
            gcnt  <= 32'(GAP_CYCLES - 1);
            state <= S_GAP;
          end else if (tout_hit) begin
            tx_en       <= 1'b0;
            timeout_err <= 1'b1;
            gcnt        <= 32'(GAP_CYCLES - 1);
            state       <= S_GAP;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        S_GAP: begin
          if (gcnt == 32'd0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gcnt <= gcnt - 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant       = grant;
  assign bus.done        = done;
  assign bus.timeout_err = timeout_err;
  assign bus.busy        = busy;
  assign bus.owner       = owner;
  assign bus.tx_en       = tx_en;
  assign bus.tx_data     = tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: drives uart_tx_arbiter with directed scenarios and a
// randomized requester/UART population; every cycle the outputs are compared
// with a transaction-level reference model of the arbiter.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int DATA_W         = 128;
  localparam int GAP_CYCLES     = 4;
  localparam int TIMEOUT_CYCLES = 50;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus();

  logic [DATA_W-1:0] frm [NUM_REQ];

  always_comb begin
    bus.req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = frm[i];
  end

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W),
    .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model (one transaction at a time) -----------
  typedef enum int {M_IDLE, M_SEND, M_GAP} mode_t;
  mode_t             m_mode = M_IDLE;
  int                m_ptr = 0, m_age = 0, m_gap = 0, m_owner = 0;
  logic [3:0]        m_grant = '0, m_done = '0;
  logic              m_to = 1'b0, m_busy = 1'b0, m_en = 1'b0;
  logic [DATA_W-1:0] m_data = '0;

  task automatic model_edge();
    int  c;
    bit  found;
    m_grant = '0;
    m_done  = '0;
    m_to    = 1'b0;
    if (reset) begin
      m_mode = M_IDLE; m_ptr = 0; m_age = 0; m_gap = 0; m_owner = 0;
      m_busy = 1'b0; m_en = 1'b0; m_data = '0;
    end else begin
      case (m_mode)
        M_IDLE: if (bus.req != 0) begin
          found = 0;
          for (int i = 0; i < NUM_REQ; i++) begin
            c = (m_ptr + i) % NUM_REQ;
            if (!found && bus.req[c]) begin
              found = 1;
              m_owner = c;
            end
          end
          m_grant[m_owner] = 1'b1;
          m_ptr  = (m_owner + 1) % NUM_REQ;
          m_en   = 1'b1;
          m_data = frm[m_owner];
          m_busy = 1'b1;
          m_age  = 0;
          m_mode = M_SEND;
        end
        M_SEND: begin
          if (bus.tx_done) begin
            m_en = 1'b0;
            m_done[m_owner] = 1'b1;
            m_gap = GAP_CYCLES;
            m_mode = M_GAP;
          end else if (m_age + 1 == TIMEOUT_CYCLES) begin
            m_en = 1'b0;
            m_to = 1'b1;
            m_gap = GAP_CYCLES;
            m_mode = M_GAP;
          end else begin
            m_age++;
          end
        end
        default: begin
          m_gap--;
          if (m_gap == 0) begin
            m_mode = M_IDLE;
            m_busy = 1'b0;
          end
        end
      endcase
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then
  // compare every output shortly after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_eq("m_grant", bus.grant, m_grant);
    check_eq("m_done", bus.done, m_done);
    check_eq("m_timeout", bus.timeout_err, m_to);
    check_eq("m_busy", bus.busy, m_busy);
    check_eq("m_owner", bus.owner, 3'(m_owner));
    check_eq("m_tx_en", bus.tx_en, m_en);
    check_eq("m_tx_data", bus.tx_data, m_data);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    bus.tx_done = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    logic [DATA_W-1:0] sr_frame;
    int last, ng, since, seen_to, done_seen, to_seen, wait_n;
    bit hang;

    for (int i = 0; i < NUM_REQ; i++) frm[i] = '0;
    bus.req = '0;
    bus.tx_done = 1'b0;

    // ---- reset state
    do_reset();
    check_eq("rst_grant", bus.grant, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_tx_en", bus.tx_en, 0);
    check_eq("rst_tx_data", bus.tx_data, 0);
    check_eq("rst_owner", bus.owner, 0);

    // ---- single request, with spurious tx_done in GAP and IDLE
    sr_frame = 128'hDEADBEEF_0123_4567_89AB_CDEF_CAFEF00D;
    frm[2] = sr_frame;
    bus.req = 4'b0100;
    step();
    check_eq("sr_grant", bus.grant, 4'b0100);
    check_eq("sr_tx_data", bus.tx_data, sr_frame);
    check_eq("sr_tx_en", bus.tx_en, 1);
    bus.req = '0;
    for (int k = 0; k < 19; k++) step();
    check_eq("sr_tx_en_held", bus.tx_en, 1);
    bus.tx_done = 1'b1;
    step();
    check_eq("sr_done", bus.done, 4'b0100);
    check_eq("sr_tx_en_low", bus.tx_en, 0);
    // tx_done left high through the gap must not produce another done
    for (int k = 1; k <= GAP_CYCLES; k++) begin
      step();
      check_eq("gap_spur_done", bus.done, 0);
      check_eq("sr_busy_gap", bus.busy, (k < GAP_CYCLES) ? 1 : 0);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("idle_spur_done", bus.done, 0);
      check_eq("idle_spur_tx_en", bus.tx_en, 0);
      check_eq("idle_spur_busy", bus.busy, 0);
    end
    bus.tx_done = 1'b0;

    // ---- round robin, all requests held
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) frm[i] = {$urandom, $urandom, $urandom, $urandom};
    bus.req = 4'b1111;
    last = 0; ng = 0; since = -1;
    for (int t = 0; t < 150 && ng < 5; t++) begin
      bus.tx_done = (since == 10);
      step();
      if (since >= 0) since++;
      if (bus.grant != 0) begin
        check_eq("rr_owner", bus.owner, order[ng]);
        check_eq("rr_grant", bus.grant, 4'b0001 << order[ng]);
        if (ng > 0) check_eq("rr_spacing", cyc - last, 10 + GAP_CYCLES + 2);
        last = cyc;
        ng++;
        since = 0;
      end
    end
    check_eq("rr_count", ng, 5);
    bus.tx_done = 1'b0;

    // ---- timeout, requester 2 waiting
    do_reset();
    bus.req = 4'b0110;
    step();
    check_eq("to_grant", bus.grant, 4'b0010);
    bus.req = 4'b0100;
    seen_to = -1; done_seen = 0;
    for (int k = 1; k <= 60 && seen_to < 0; k++) begin
      step();
      if (bus.done != 0) done_seen = 1;
      if (bus.timeout_err) seen_to = k;
    end
    check_eq("to_cycle", seen_to, TIMEOUT_CYCLES);
    check_eq("to_no_done", done_seen, 0);
    check_eq("to_tx_en", bus.tx_en, 0);
    wait_n = -1;
    for (int k = 1; k <= 20 && wait_n < 0; k++) begin
      step();
      if (bus.grant != 0) begin
        wait_n = k;
        check_eq("to_next_grant", bus.grant, 4'b0100);
      end
    end
    check_eq("to_next_wait", wait_n, GAP_CYCLES + 1);
    bus.req = '0;

    // ---- tx_done on the timeout cycle
    do_reset();
    bus.req = 4'b0001;
    step();
    check_eq("race_grant", bus.grant, 4'b0001);
    bus.req = '0;
    to_seen = 0;
    for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
      bus.tx_done = (k == TIMEOUT_CYCLES);
      step();
      if (bus.timeout_err) to_seen = 1;
    end
    bus.tx_done = 1'b0;
    check_eq("race_done", bus.done, 4'b0001);
    check_eq("race_no_timeout", to_seen, 0);

    // ---- reset in the middle of SEND
    do_reset();
    bus.req = 4'b1000;
    step();
    check_eq("mid_grant", bus.grant, 4'b1000);
    bus.req = '0;
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1;
    step();
    check_eq("mid_tx_en", bus.tx_en, 0);
    check_eq("mid_busy", bus.busy, 0);
    check_eq("mid_done", bus.done, 0);
    check_eq("mid_owner", bus.owner, 0);
    check_eq("mid_tx_data", bus.tx_data, 0);
    reset = 1'b0;
    bus.req = 4'b1010;
    step();
    check_eq("mid_regrant", bus.grant, 4'b0010);
    bus.req = '0;

    // ---- randomized traffic
    do_reset();
    hang = 0;
    for (int t = 0; t < 3000; t++) begin
      reset = ($urandom_range(0, 399) == 0);
      bus.tx_done = bus.tx_en ? (!hang && $urandom_range(0, 9) == 0)
                              : ($urandom_range(0, 7) == 0);
      step();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.grant[i]) begin
          bus.req[i] = 1'b0;
          hang = ($urandom_range(0, 5) == 0);
        end else if (!bus.req[i] && $urandom_range(0, 15) == 0) begin
          frm[i] = {$urandom, $urandom, $urandom, $urandom};
          bus.req[i] = 1'b1;
        end
      end
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single 128-bit UART transmit path among several requesters. It sits between client blocks and the `uart` top, driving `en_tx`/`data_in` and consuming `u_tx_done`. It sequences one 128-bit frame at a time, returns a per-requester completion pulse, and enforces an inter-frame gap and a stuck-transmitter timeout.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 128: frame width; must match the UART datapath.
- `GAP_CYCLES`, 4: idle cycles between frames, minimum 1.
- `TIMEOUT_CYCLES`, 1000000: maximum cycles in SEND awaiting `tx_done`; 0 disables. Held in a 32-bit counter.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `req` input NUM_REQ: level request per requester.
- `req_data` input NUM_REQ*DATA_W: requester i's frame in bits [i*DATA_W +: DATA_W].
- `grant` output NUM_REQ: one-hot, one-cycle pulse on frame acceptance.
- `done` output NUM_REQ: one-hot, one-cycle pulse when the owner's frame completes.
- `timeout_err` output 1: one-cycle pulse on timeout.
- `busy` output 1: high in SEND and GAP.
- `owner` output 3: index of the current or last granted requester.
- `tx_en` output 1: drives UART `en_tx`.
- `tx_data` output DATA_W: drives UART `data_in`.
- `tx_done` input 1: from UART `u_tx_done`.

## Operation
- States are IDLE, SEND and GAP. All outputs are registered.
- **IDLE**, when `req != 0`:
  - Select the first asserted `req` scanning upward from `ptr`, wrapping modulo NUM_REQ.
  - Register `tx_data <= req_data[sel]`, `tx_en <= 1`, `grant[sel] <= 1`, `owner <= sel`, `ptr <= (sel+1) mod NUM_REQ`, and clear the timeout counter.
  - Go to SEND.
- **SEND**:
  - `req` is ignored.
  - `tx_data` is held constant.
  - `tx_en` stays high as a level until `tx_done` is sampled high.
- **SEND, on `tx_done = 1`**:
  - Set `tx_en <= 0` and `done[owner] <= 1`.
  - Load the gap counter with GAP_CYCLES-1.
  - Go to GAP.
- **SEND, timeout**: the timeout counter reaches TIMEOUT_CYCLES-1 while `tx_done = 0`.
  - Set `tx_en <= 0` and `timeout_err <= 1`.
  - No `done` pulse.
  - Go to GAP.
- If `tx_done` and the timeout condition occur in the same cycle, `tx_done` wins: normal completion, no error.
- **GAP**: decrement the counter each cycle; at 0, go to IDLE. `tx_en = 0` throughout.
- Requester contract:
  - Hold `req_data` stable while `req` is high and until `grant` is seen.
  - Drop `req` the cycle after `grant`.
  - A `req` still high when the arbiter returns to IDLE is treated as a new frame.
- `tx_done` sampled in IDLE or GAP is ignored.
- `grant` and `done` are never high for the same requester in the same cycle.
- Reset value of every output is 0: `grant`, `done`, `timeout_err`, `busy`, `owner`, `tx_en`, `tx_data`. Reset also sets `ptr = 0`, clears both counters, and puts the state in IDLE.
- Reset mid-SEND drops `tx_en` on the next edge and abandons the frame. No `done` and no `timeout_err` are issued.

## Timing
- `req` sampled high at edge N (IDLE): `grant`, `tx_en` and `tx_data` are valid after edge N, i.e. in cycle N+1.
- `tx_done` sampled high at edge M: `done[owner]` is high and `tx_en` low in cycle M+1.
- Gap: IDLE is reached GAP_CYCLES cycles after the `done` cycle. The earliest next `grant` is GAP_CYCLES+1 cycles after `done`.
- Timeout: `timeout_err` rises exactly TIMEOUT_CYCLES cycles after `grant` when `tx_done` never arrives.
- `busy` rises with `grant` and falls on entry to IDLE.
- Throughput: one frame per (UART frame time + GAP_CYCLES + 2) cycles.

## Test plan
- **Single request**: `req = 4'b0100`, `req_data[2] = 128'hDEADBEEF_...`, `tx_done` pulsed 20 cycles after `tx_en` rises.
  - `grant = 4'b0100` one cycle after `req`; `tx_data` equals the frame.
  - `done = 4'b0100` one cycle after `tx_done`.
  - `busy` falls GAP_CYCLES later.
- **Round-robin**: all four `req` held continuously after reset, each `tx_done` after 10 cycles.
  - Grant order is 0, 1, 2, 3, 0.
  - Successive grants are spaced 10 + GAP_CYCLES + 2 cycles apart.
- **Timeout**: TIMEOUT_CYCLES = 50, `req[1]`, `tx_done` never asserted.
  - `timeout_err` rises 50 cycles after `grant`; no `done`.
  - `tx_en` drops; the next grant goes to requester 2 if requesting.
- **Race**: `tx_done` asserted exactly on the timeout cycle.
  - `done[owner]` pulses; `timeout_err` stays 0.
- **Reset mid-SEND**: `reset` asserted 5 cycles into SEND.
  - All outputs are 0 after the edge; no `done`.
  - After release, `req = 4'b1010` grants requester 1 (`ptr` reset to 0).
- **Spurious `tx_done` in IDLE and GAP**: no `done`, no state change, `tx_en` stays 0.
